snitch_acc_share: RTL and testbench
===================================

# snitch_acc_share

Arbitrates the accelerator offload ports of `NumCores` Snitch cores onto one shared accelerator (the shared MUL/DIV unit selected by `shared_offload`). Requests are granted round-robin with grant locking under back-pressure. The requester index of every accepted request is recorded in order, so the in-order response stream can be routed back to the originating core. The block sits in the tile between the cores' `acc_req_t`/`acc_resp_t` ports and the shared unit.

## Interface
- `NumCores`, 4: number of requesting cores; must be ≥2.
- `MaxOutstanding`, 4: maximum number of accepted requests without a response; sets the tag FIFO depth; must be ≥1.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `core_qvalid_i`  in  NumCores  per-core request valid.
- `core_qready_o`  out  NumCores  per-core request ready.
- `core_qdata_i`  in  NumCores×$bits(acc_req_t)  per-core request payload.
- `core_pvalid_o`  out  NumCores  per-core response valid.
- `core_pready_i`  in  NumCores  per-core response ready.
- `core_pdata_o`  out  NumCores×$bits(acc_resp_t)  response payload; the same value is broadcast to all cores.
- `acc_qvalid_o` / `acc_qready_i` / `acc_qdata_o`  out/in/out  1/1/$bits(acc_req_t)  request port to the shared unit.
- `acc_pvalid_i` / `acc_pready_o` / `acc_pdata_i`  in/out/in  1/1/$bits(acc_resp_t)  response port from the shared unit; responses arrive in request order.
- `stall_cnt_o`  out  NumCores×32  per-core contention counters (see Configuration).

## Operation
- Handshake rules:
  - A transfer happens on valid && ready.
  - Once a core raises `core_qvalid_i`, it holds valid and data stable until ready.
  - The block keeps `acc_qvalid_o`/`acc_qdata_o` stable until `acc_qready_i`.
- State:
  - `rr_ptr` (idx_width(NumCores) bits).
  - `lock_q` and `lock_idx_q`.
  - `cnt_q` (0..MaxOutstanding).
  - Tag FIFO of core indices.
- Arbitration, when unlocked: grant the first core with valid, scanning from `rr_ptr` upward and wrapping at NumCores−1 → 0.
- Arbitration, when locked: grant `lock_idx_q`.
- Request path:
  - `acc_qvalid_o` = any candidate valid && `cnt_q` < MaxOutstanding.
  - `acc_qdata_o` = the granted core's data.
  - `core_qready_o[g]` = `acc_qready_i` && `cnt_q` < MaxOutstanding; all other readies are 0.
- On a request handshake:
  - push g into the tag FIFO;
  - `rr_ptr` ← (g+1) mod NumCores;
  - clear the lock.
- If `acc_qvalid_o` && !`acc_qready_i`: set `lock_q`, `lock_idx_q` ← g.
- Response path:
  - head = tag FIFO head;
  - `core_pvalid_o[head]` = `acc_pvalid_i` && FIFO not empty, all others 0;
  - `acc_pready_o` = `core_pready_i[head]`;
  - a response handshake pops the FIFO.
- `cnt_q`:
  - +1 on request handshake only;
  - −1 on response handshake only;
  - unchanged when both happen in the same cycle.
- Full boundary: when `cnt_q` == MaxOutstanding, requests are blocked even if a response pops in the same cycle. This avoids a path from `core_pready_i` to `core_qready_o`.
- Empty boundary: `acc_pvalid_i` with an empty FIFO is a protocol error. An assertion fires; `acc_pready_o` = 1 and the response is discarded.
- The response `id` and `data` fields pass through unmodified. The request payload passes through unmodified.

## Timing
- Request path: 0-cycle combinational (`core_qvalid_i` → `acc_qvalid_o`, `acc_qready_i` → `core_qready_o`). No registers in the data path.
- Response path: 0-cycle combinational.
- Reset values:
  - all `core_qready_o`, `core_pvalid_o`, `acc_qvalid_o` are 0;
  - `acc_pready_o` = 0;
  - `rr_ptr` = 0 (core 0 has first priority);
  - lock cleared, `cnt_q` = 0, FIFO empty, `stall_cnt_o` = 0.
- Reset asserted mid-transaction discards all outstanding tags. Upstream and the shared unit are reset together.
- Sustained throughput: one request per cycle while `cnt_q` < MaxOutstanding and responses drain.

## Configuration
- `SNITCH_ACC_SHARE_PERF_EN` defined:
  - `stall_cnt_o[i]` increments every cycle with `core_qvalid_i[i]` && !`core_qready_o[i]`;
  - the counter saturates at 32'hFFFF_FFFF;
  - it resets to 0.
- `SNITCH_ACC_SHARE_PERF_EN` undefined: `stall_cnt_o` is tied to 0 and no counter flops are instantiated.

## Structure
- `snitch_pkg` owns:
  - `acc_req_t` and `acc_resp_t`;
  - new `localparam int AccShareMaxOutstanding = 4`;
  - new `typedef logic [idx_width(NumCores)-1:0]` core index type, parameterized through the module parameter.
- One sub-module, `snitch_acc_share_tag_fifo`:
  - synchronous FIFO, width idx_width(NumCores), depth MaxOutstanding;
  - push/pop/full/empty flags;
  - simultaneous push and pop allowed when not empty.

## Test plan
- Single requester: core 2 sends 3 MULs with `acc_qready_i`=1 and the unit responds in order → 3 requests forwarded unchanged; responses appear only on `core_pvalid_o[2]`; `cnt_q` returns to 0.
- All 4 cores valid every cycle with ready=1 → grant sequence 0,1,2,3,0,1…; no core is starved.
- Core 1 granted with `acc_qready_i` held 0 for 5 cycles while core 0 raises valid → `acc_qdata_o` stays core 1's payload; core 1 handshakes on cycle 6; core 0 follows.
- MaxOutstanding=4 with no responses → the 5th request sees `core_qready_o`=0. Response and request in the same cycle at full → request still blocked that cycle and accepted the next.
- Interleaved requests from cores 3,0,3 → responses routed to 3,0,3. `core_pready_i[0]`=0 for 2 cycles → `acc_pready_o`=0 and that response is held.
- With `SNITCH_ACC_SHARE_PERF_EN`, core 2 blocked for 7 cycles → `stall_cnt_o[2]`=7. Without the macro → `stall_cnt_o`=0.

Source files
------------

// File: rtl/snitch_pkg.sv
// Shared Snitch types for the accelerator offload interface.
// Also holds the tag-depth default and index-width helper for snitch_acc_share.
package snitch_pkg;

    // Default tag FIFO depth for the shared accelerator port.
    localparam int AccShareMaxOutstanding = 4;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data_op;
        logic [31:0] data_arga;
        logic [31:0] data_argb;
    } acc_req_t;

    typedef struct packed {
        logic [4:0]  id;
        logic        error;
        logic [31:0] data;
    } acc_resp_t;

    // Index width that stays at least 1 bit wide for degenerate counts.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snitch_acc_share_tag_fifo.sv
// Tag FIFO for snitch_acc_share: stores the requester index of each accepted request
// so that in-order responses can be routed back.
// Ports: clk_i/rst_ni, push_i/data_i (write), pop_i/data_o (read head), full_o, empty_o.
// Push while full and pop while empty are ignored; push and pop together are fine when
// the FIFO is not empty.
module snitch_acc_share_tag_fifo import snitch_pkg::*; #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/snitch_acc_share.sv
// Shares one accelerator port (e.g. the shared MUL/DIV unit) among NumCores Snitch cores.
// Requests: round-robin arbitration, grant locked while the unit back-pressures.
// Responses: in order; a tag FIFO of requester indices routes each one back.
// Ports: core_q*/core_p* per-core offload request/response, acc_q*/acc_p* shared unit,
//        stall_cnt_o per-core contention counters.
// Optional feature: define SNITCH_ACC_SHARE_PERF_EN to build saturating stall counters;
// otherwise stall_cnt_o is tied to zero.
module snitch_acc_share import snitch_pkg::*; #(
    parameter int unsigned NumCores       = 4,
    parameter int unsigned MaxOutstanding = AccShareMaxOutstanding
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic      [NumCores-1:0]       core_qvalid_i,
    output logic      [NumCores-1:0]       core_qready_o,
    input  acc_req_t  [NumCores-1:0]       core_qdata_i,
    output logic      [NumCores-1:0]       core_pvalid_o,
    input  logic      [NumCores-1:0]       core_pready_i,
    output acc_resp_t [NumCores-1:0]       core_pdata_o,
    output logic                         acc_qvalid_o,
    input  logic                         acc_qready_i,
    output acc_req_t                     acc_qdata_o,
    input  logic                         acc_pvalid_i,
    output logic                         acc_pready_o,
    input  acc_resp_t                    acc_pdata_i,
    output logic      [NumCores-1:0][31:0] stall_cnt_o
);

    localparam int unsigned IdxW = idx_width(NumCores);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef logic [IdxW-1:0] core_idx_t;

    core_idx_t       rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, gnt_idx, head_idx;
    logic            lock_q, lock_d, gnt_valid, can_issue, req_hs, rsp_hs;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] cnt_q, cnt_d;
    int unsigned     cand;

    // Arbitration: a locked grant wins, otherwise scan upward from rr_ptr_q.
    always_comb begin
        gnt_idx   = rr_ptr_q;
        gnt_valid = 1'b0;
        cand      = 0;
        if (lock_q) begin
            gnt_idx   = lock_idx_q;
            gnt_valid = core_qvalid_i[lock_idx_q];
        end else begin
            for (int unsigned k = 0; k < NumCores; k++) begin
                cand = (32'(rr_ptr_q) + k) % NumCores;
                if (!gnt_valid && core_qvalid_i[core_idx_t'(cand)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = core_idx_t'(cand);
                end
            end
        end
    end

    // Full check uses only cnt_q, so core_pready_i never reaches core_qready_o.
    assign can_issue    = (cnt_q < CntW'(MaxOutstanding));
    assign acc_qvalid_o = gnt_valid && can_issue;
    assign acc_qdata_o  = core_qdata_i[gnt_idx];
    assign req_hs       = acc_qvalid_o && acc_qready_i;

    always_comb begin
        core_qready_o          = '0;
        core_qready_o[gnt_idx] = gnt_valid && acc_qready_i && can_issue;
    end

    // Response routing. A response with no tag is drained (ready follows valid).
    always_comb begin
        core_pvalid_o           = '0;
        core_pvalid_o[head_idx] = acc_pvalid_i && !fifo_empty;
        acc_pready_o            = fifo_empty ? acc_pvalid_i : core_pready_i[head_idx];
        for (int unsigned i = 0; i < NumCores; i++) core_pdata_o[i] = acc_pdata_i;
    end

    assign rsp_hs = acc_pvalid_i && acc_pready_o && !fifo_empty;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        cnt_d      = cnt_q;
        if (req_hs) begin
            rr_ptr_d = (gnt_idx == core_idx_t'(NumCores - 1)) ? '0 : gnt_idx + 1'b1;
            lock_d   = 1'b0;
        end else if (acc_qvalid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
        unique case ({req_hs, rsp_hs})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    snitch_acc_share_tag_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_hs),
        .data_i  (gnt_idx),
        .pop_i   (rsp_hs),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef SNITCH_ACC_SHARE_PERF_EN
    logic [NumCores-1:0][31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int unsigned i = 0; i < NumCores; i++) begin
            if (core_qvalid_i[i] && !core_qready_o[i] && (stall_cnt_q[i] != '1)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    // Protocol checks: no response without an outstanding tag, no push into a full FIFO.
    a_rsp_has_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(acc_pvalid_i && fifo_empty));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_hs && fifo_full));

endmodule

// File: tb/tb_snitch_acc_share.sv
module tb_snitch_acc_share;
    import snitch_pkg::*;

    localparam int N = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic      [N-1:0]       core_qvalid_i, core_qready_o, core_pvalid_o, core_pready_i;
    acc_req_t  [N-1:0]       core_qdata_i;
    acc_resp_t [N-1:0]       core_pdata_o;
    logic                  acc_qvalid_o, acc_qready_i, acc_pvalid_i, acc_pready_o;
    acc_req_t              acc_qdata_o;
    acc_resp_t             acc_pdata_i;
    logic      [N-1:0][31:0] stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    snitch_acc_share #(
        .NumCores       (N),
        .MaxOutstanding (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .core_qvalid_i (core_qvalid_i),
        .core_qready_o (core_qready_o),
        .core_qdata_i  (core_qdata_i),
        .core_pvalid_o (core_pvalid_o),
        .core_pready_i (core_pready_i),
        .core_pdata_o  (core_pdata_o),
        .acc_qvalid_o  (acc_qvalid_o),
        .acc_qready_i  (acc_qready_i),
        .acc_qdata_o   (acc_qdata_o),
        .acc_pvalid_i  (acc_pvalid_i),
        .acc_pready_o  (acc_pready_o),
        .acc_pdata_i   (acc_pdata_i),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] qvalid;
        logic         pvalid;
        logic [N-1:0] exp_qready;
        logic [N-1:0] exp_pvalid;
    } rr_vec_t;

    rr_vec_t rr_tab[9];

    function automatic acc_req_t mk_req(int core, int n);
        acc_req_t r;
        r.id        = 5'(n);
        r.data_op   = 32'h0200_0033 + 32'(n);
        r.data_arga = 32'h1000_0000 + 32'(core * 256 + n);
        r.data_argb = 32'hB000_0000 | 32'(n);
        return r;
    endfunction

    function automatic acc_resp_t mk_rsp(int n);
        acc_resp_t r;
        r.id    = 5'(n);
        r.error = 1'b0;
        r.data  = 32'hD000_0000 + 32'(n);
        return r;
    endfunction

    function automatic int oh2idx(logic [N-1:0] oh);
        int idx = 0;
        for (int i = 0; i < N; i++) if (oh[i]) idx = i;
        return idx;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input int n);
        for (int c = 0; c < N; c++) core_qdata_i[c] = mk_req(c, n);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        core_qvalid_i = '0;
        acc_qready_i  = 1'b1;
        acc_pvalid_i  = 1'b0;
        core_pready_i = '1;
        acc_pdata_i   = mk_rsp(0);
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic drain(input logic [N-1:0] exp_pv, input int n);
        acc_pvalid_i = 1'b1;
        acc_pdata_i  = mk_rsp(n);
        #1;
        check("drain_pvalid", 128'(core_pvalid_o), 128'(exp_pv));
        step();
        acc_pvalid_i = 1'b0;
    endtask

    initial begin
        rr_tab[0] = '{4'b1111, 1'b0, 4'b0001, 4'b0000};
        rr_tab[1] = '{4'b1111, 1'b1, 4'b0010, 4'b0001};
        rr_tab[2] = '{4'b1111, 1'b1, 4'b0100, 4'b0010};
        rr_tab[3] = '{4'b1111, 1'b1, 4'b1000, 4'b0100};
        rr_tab[4] = '{4'b1111, 1'b1, 4'b0001, 4'b1000};
        rr_tab[5] = '{4'b1111, 1'b1, 4'b0010, 4'b0001};
        rr_tab[6] = '{4'b0101, 1'b1, 4'b0100, 4'b0010};
        rr_tab[7] = '{4'b0001, 1'b1, 4'b0001, 4'b0100};
        rr_tab[8] = '{4'b0000, 1'b1, 4'b0000, 4'b0001};

        // Reset state, with the unit ready and all cores ready for responses.
        idle();
        set_data(0);
        rst_ni = 1'b0;
        step();
        check("rst_qready", 128'(core_qready_o), 128'(0));
        check("rst_acc_qvalid", 128'(acc_qvalid_o), 128'(0));
        check("rst_pvalid", 128'(core_pvalid_o), 128'(0));
        check("rst_acc_pready", 128'(acc_pready_o), 128'(0));
        check("rst_stall", 128'(stall_cnt_o), 128'(0));
        step();
        rst_ni = 1'b1;

        // Single requester: core 2, three requests, then three in-order responses.
        for (int k = 0; k < 3; k++) begin
            set_data(k);
            core_qvalid_i = 4'b0100;
            #1;
            check("single_acc_qvalid", 128'(acc_qvalid_o), 128'(1));
            check("single_qdata", 128'(acc_qdata_o), 128'(mk_req(2, k)));
            check("single_qready", 128'(core_qready_o), 128'(4'b0100));
            step();
        end
        core_qvalid_i = '0;
        for (int k = 0; k < 3; k++) begin
            acc_pvalid_i = 1'b1;
            acc_pdata_i  = mk_rsp(k);
            #1;
            check("single_pvalid", 128'(core_pvalid_o), 128'(4'b0100));
            check("single_acc_pready", 128'(acc_pready_o), 128'(1));
            check("single_pdata", 128'(core_pdata_o[2]), 128'(mk_rsp(k)));
            step();
        end
        acc_pvalid_i = 1'b0;

        // Full boundary: outstanding count back at 0, so four requests go through.
        for (int k = 0; k < 4; k++) begin
            set_data(10 + k);
            core_qvalid_i = 4'b1000;
            #1;
            check("full_accept", 128'(core_qready_o), 128'(4'b1000));
            step();
        end
        #1;
        check("full_block_qready", 128'(core_qready_o), 128'(0));
        check("full_block_qvalid", 128'(acc_qvalid_o), 128'(0));
        acc_pvalid_i = 1'b1;
        acc_pdata_i  = mk_rsp(20);
        #1;
        check("full_pop_still_blocked", 128'(core_qready_o), 128'(0));
        check("full_pop_pvalid", 128'(core_pvalid_o), 128'(4'b1000));
        step();
        acc_pvalid_i = 1'b0;
        #1;
        check("full_accept_after_pop", 128'(core_qready_o), 128'(4'b1000));
        step();
        core_qvalid_i = '0;
        for (int k = 0; k < 4; k++) drain(4'b1000, 21 + k);

        // Round-robin with responses draining every cycle.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_data(30 + i);
            core_qvalid_i = rr_tab[i].qvalid;
            acc_pvalid_i  = rr_tab[i].pvalid;
            acc_pdata_i   = mk_rsp(30 + i);
            #1;
            check("rr_qready", 128'(core_qready_o), 128'(rr_tab[i].exp_qready));
            check("rr_pvalid", 128'(core_pvalid_o), 128'(rr_tab[i].exp_pvalid));
            check("rr_acc_qvalid", 128'(acc_qvalid_o), 128'(rr_tab[i].exp_qready != '0));
            if (rr_tab[i].exp_qready != '0) begin
                check("rr_qdata", 128'(acc_qdata_o),
                      128'(mk_req(oh2idx(rr_tab[i].exp_qready), 30 + i)));
            end
            step();
        end
        idle();

        // Grant lock: core 1 held under back-pressure while core 0 joins.
        do_reset();
        set_data(40);
        acc_qready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            core_qvalid_i = (c >= 2) ? 4'b0011 : 4'b0010;
            #1;
            check("lock_qvalid", 128'(acc_qvalid_o), 128'(1));
            check("lock_qdata", 128'(acc_qdata_o), 128'(mk_req(1, 40)));
            check("lock_qready", 128'(core_qready_o), 128'(0));
            step();
        end
        acc_qready_i = 1'b1;
        #1;
        check("lock_release", 128'(core_qready_o), 128'(4'b0010));
        check("lock_release_data", 128'(acc_qdata_o), 128'(mk_req(1, 40)));
        step();
        core_qvalid_i = 4'b0001;
        #1;
        check("lock_next", 128'(core_qready_o), 128'(4'b0001));
        check("lock_next_data", 128'(acc_qdata_o), 128'(mk_req(0, 40)));
        step();
        core_qvalid_i = '0;
        drain(4'b0010, 41);
        drain(4'b0001, 42);

        // Contention counter: core 2 blocked for seven cycles.
        do_reset();
        set_data(60);
        core_qvalid_i = 4'b0100;
        acc_qready_i  = 1'b0;
        repeat (7) step();
        acc_qready_i = 1'b1;
        #1;
        check("stall_handshake", 128'(core_qready_o), 128'(4'b0100));
        step();
        core_qvalid_i = '0;
        #1;
`ifdef SNITCH_ACC_SHARE_PERF_EN
        check("stall_cnt2", 128'(stall_cnt_o[2]), 128'(7));
`else
        check("stall_cnt2", 128'(stall_cnt_o[2]), 128'(0));
`endif
        check("stall_cnt0", 128'(stall_cnt_o[0]), 128'(0));
        drain(4'b0100, 61);

        // Interleaved 3,0,3 with core 0 back-pressuring its response.
        do_reset();
        set_data(50);
        core_qvalid_i = 4'b1000;
        #1;
        check("il_q0", 128'(core_qready_o), 128'(4'b1000));
        step();
        core_qvalid_i = 4'b0001;
        #1;
        check("il_q1", 128'(core_qready_o), 128'(4'b0001));
        step();
        core_qvalid_i = 4'b1000;
        #1;
        check("il_q2", 128'(core_qready_o), 128'(4'b1000));
        step();
        core_qvalid_i = '0;
        drain(4'b1000, 50);
        acc_pvalid_i  = 1'b1;
        acc_pdata_i   = mk_rsp(51);
        core_pready_i = 4'b1110;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("il_hold_pvalid", 128'(core_pvalid_o), 128'(4'b0001));
            check("il_hold_pready", 128'(acc_pready_o), 128'(0));
            check("il_hold_pdata", 128'(core_pdata_o[0]), 128'(mk_rsp(51)));
            step();
        end
        core_pready_i = '1;
        #1;
        check("il_release_pvalid", 128'(core_pvalid_o), 128'(4'b0001));
        check("il_release_pready", 128'(acc_pready_o), 128'(1));
        step();
        drain(4'b1000, 52);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
